// File: rtl/sysid_checker.sv
// ---------------------------------------------------------------------------
// sysid_checker
//
// Boot-time consumer of the system ID peripheral. After reset it acts as an
// Avalon-MM read master and fetches word 0 (system ID) and word 1 (build
// timestamp) from the sysid slave. It then compares both words with the
// expected build constants. A mismatch triggers a retry of the full read
// pass, a stalled slave is caught by a timeout, and the sticky pass/fail
// status is presented to the board-level reset and status logic.
//
// Ports
//   clk             : sole clock
//   reset           : asynchronous, active-high reset
//   start           : single-cycle restart request, honoured only in DONE
//   address         : Avalon word select (0 = ID, 1 = timestamp)
//   read            : Avalon read strobe
//   waitrequest     : slave stall; a read is accepted when read & !waitrequest
//   readdata        : slave read data
//   id_value        : last captured word 0
//   timestamp_value : last captured word 1
//   busy            : a check is in progress
//   done            : check finished, status outputs valid
//   pass            : both words matched
//   fail            : retries exhausted, or timeout
//   timeout         : the slave stalled beyond TIMEOUT_CYCLES
//   retry_count     : number of retries consumed
// ---------------------------------------------------------------------------
module sysid_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'd807520620,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1321024492,
  parameter int unsigned READ_LATENCY       = 1,
  parameter int unsigned MAX_RETRIES        = 3,
  parameter int unsigned TIMEOUT_CYCLES     = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        address,
  output logic        read,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  output logic [31:0] id_value,
  output logic [31:0] timestamp_value,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic        timeout,
  output logic [3:0]  retry_count
);

  localparam int unsigned DATA_W = 32;

  // Last latency-cycle index; unused when the slave has zero latency.
  localparam logic [1:0] LAT_LAST    = (READ_LATENCY > 0) ? 2'(READ_LATENCY - 1) : 2'd0;
  localparam bit         ZERO_LAT    = (READ_LATENCY == 0);
  localparam logic [7:0] STALL_LIMIT = 8'(TIMEOUT_CYCLES);
  localparam logic [3:0] RETRY_LIMIT = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    START,
    RD_ID,
    LAT_ID,
    RD_TS,
    LAT_TS,
    CHECK,
    DONE
  } state_t;

  state_t     state;
  logic [1:0] lat_cnt;
  logic [7:0] stall_cnt;

  function automatic logic words_match(input logic [DATA_W-1:0] id_w,
                                       input logic [DATA_W-1:0] ts_w);
    return (id_w == EXPECTED_ID) && (ts_w == EXPECTED_TIMESTAMP);
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= START;
      lat_cnt         <= 2'd0;
      stall_cnt       <= 8'd0;
      address         <= 1'b0;
      read            <= 1'b0;
      id_value        <= '0;
      timestamp_value <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      fail            <= 1'b0;
      timeout         <= 1'b0;
      retry_count     <= 4'd0;
    end else begin
      case (state)
        // First edge after release only raises busy; the ID read strobe
        // follows on the next edge.
        START: begin
          if (!busy) begin
            busy <= 1'b1;
          end else begin
            state     <= RD_ID;
            read      <= 1'b1;
            address   <= 1'b0;
            stall_cnt <= 8'd0;
          end
        end

        // Timeout has priority: once the stall counter has reached the
        // limit the strobe is withdrawn whatever waitrequest does.
        RD_ID, RD_TS: begin
          if (stall_cnt == STALL_LIMIT) begin
            state   <= DONE;
            read    <= 1'b0;
            timeout <= 1'b1;
            fail    <= 1'b1;
            done    <= 1'b1;
            busy    <= 1'b0;
          end else if (!waitrequest) begin
            lat_cnt <= 2'd0;
            if (ZERO_LAT) begin
              // Data is valid in the accepting cycle itself.
              if (state == RD_ID) begin
                id_value  <= readdata;
                address   <= 1'b1;
                stall_cnt <= 8'd0;
                state     <= RD_TS;
              end else begin
                timestamp_value <= readdata;
                read            <= 1'b0;
                state           <= CHECK;
              end
            end else begin
              read <= 1'b0;
              if (state == RD_ID) begin
                state <= LAT_ID;
              end else begin
                state <= LAT_TS;
              end
            end
          end else begin
            stall_cnt <= stall_cnt + 8'd1;
          end
        end

        LAT_ID: begin
          if (lat_cnt == LAT_LAST) begin
            id_value  <= readdata;
            state     <= RD_TS;
            read      <= 1'b1;
            address   <= 1'b1;
            stall_cnt <= 8'd0;
          end else begin
            lat_cnt <= lat_cnt + 2'd1;
          end
        end

        LAT_TS: begin
          if (lat_cnt == LAT_LAST) begin
            timestamp_value <= readdata;
            state           <= CHECK;
          end else begin
            lat_cnt <= lat_cnt + 2'd1;
          end
        end

        CHECK: begin
          if (words_match(id_value, timestamp_value)) begin
            state <= DONE;
            pass  <= 1'b1;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else if (retry_count < RETRY_LIMIT) begin
            retry_count <= retry_count + 4'd1;
            state       <= RD_ID;
            read        <= 1'b1;
            address     <= 1'b0;
            stall_cnt   <= 8'd0;
          end else begin
            state <= DONE;
            fail  <= 1'b1;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end

        // Captured words are left alone on restart; they are simply
        // overwritten by the next pass.
        DONE: begin
          if (start) begin
            state       <= RD_ID;
            pass        <= 1'b0;
            fail        <= 1'b0;
            timeout     <= 1'b0;
            done        <= 1'b0;
            retry_count <= 4'd0;
            busy        <= 1'b1;
            read        <= 1'b1;
            address     <= 1'b0;
            stall_cnt   <= 8'd0;
          end
        end

        default: state <= START;
      endcase
    end
  end

endmodule

// File: tb/tb_sysid_checker.sv
// ---------------------------------------------------------------------------
// tb_sysid_checker
//
// Directed bench for sysid_checker (READ_LATENCY=1, MAX_RETRIES=3,
// TIMEOUT_CYCLES=10). A latency-1 sysid slave is modelled inside run_check;
// edges are numbered from reset release (edge 1 = first posedge after it).
// ---------------------------------------------------------------------------
module tb_sysid_checker;

  localparam logic [31:0] EXP_ID = 32'd807520620;
  localparam logic [31:0] EXP_TS = 32'd1321024492;
  localparam int NEVER = 100000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        waitrequest = 1'b0;
  logic [31:0] readdata = 32'd0;
  logic        address;
  logic        read;
  logic [31:0] id_value;
  logic [31:0] timestamp_value;
  logic        busy;
  logic        done;
  logic        pass;
  logic        fail;
  logic        timeout;
  logic [3:0]  retry_count;

  int checks = 0;
  int errors = 0;

  // Observations filled in by run_check
  int          done_edge;
  int          rd_cycles;
  int          rd_addr1_cycles;
  int          id_pulses;
  int          ts_pulses;
  int          id_acc;
  int          bad_id_passes = 0;
  logic        e1_read, e1_busy, e1_done, e1_pass, e1_fail;
  logic [3:0]  e1_retry;
  logic [31:0] e1_id;

  sysid_checker #(
    .EXPECTED_ID       (EXP_ID),
    .EXPECTED_TIMESTAMP(EXP_TS),
    .READ_LATENCY      (1),
    .MAX_RETRIES       (3),
    .TIMEOUT_CYCLES    (10)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .address        (address),
    .read           (read),
    .waitrequest    (waitrequest),
    .readdata       (readdata),
    .id_value       (id_value),
    .timestamp_value(timestamp_value),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .fail           (fail),
    .timeout        (timeout),
    .retry_count    (retry_count)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    reset       = 1'b1;
    start       = 1'b0;
    waitrequest = 1'b0;
    readdata    = 32'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Runs up to max_edges edges, sampling 1 time unit after each posedge.
  // waitrequest is high for the cycles following edges wr_from..wr_to-1
  // (edge 0 = the call point); start is high for the cycle after edge
  // start_at. Stops at the first edge where done is seen.
  task automatic run_check(input int max_edges, input int wr_from,
                           input int wr_to, input int start_at);
    logic pend_acc;
    logic pend_addr;
    logic prev_read;
    pend_acc        = 1'b0;
    pend_addr       = 1'b0;
    prev_read       = read;
    done_edge       = 0;
    rd_cycles       = 0;
    rd_addr1_cycles = 0;
    id_pulses       = 0;
    ts_pulses       = 0;
    id_acc          = 0;
    waitrequest     = (0 >= wr_from) && (0 < wr_to);
    start           = (start_at == 0);
    for (int k = 1; k <= max_edges; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) begin
        e1_read  = read;
        e1_busy  = busy;
        e1_done  = done;
        e1_pass  = pass;
        e1_fail  = fail;
        e1_retry = retry_count;
        e1_id    = id_value;
      end
      if (read) begin
        rd_cycles++;
        if (address) rd_addr1_cycles++;
      end
      if (read && !prev_read) begin
        if (address) ts_pulses++;
        else         id_pulses++;
      end
      prev_read = read;
      // Slave: data for a read accepted at the last edge is valid now and
      // is captured by the DUT at the next edge.
      if (pend_acc) begin
        if (pend_addr) begin
          readdata = EXP_TS;
        end else begin
          readdata = (id_acc < bad_id_passes) ? 32'h0000_0000 : EXP_ID;
          id_acc++;
        end
      end
      waitrequest = (k >= wr_from) && (k < wr_to);
      pend_acc    = read && !waitrequest;
      pend_addr   = address;
      start       = (k == start_at);
      if (done) begin
        done_edge = k;
        break;
      end
    end
    start       = 1'b0;
    waitrequest = 1'b0;
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({read, busy, done, pass, fail, timeout, address} !== 7'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 0000000",
               {read, busy, done, pass, fail, timeout, address});
    end
    checks++;
    if (retry_count !== 4'd0) begin
      errors++;
      $display("FAIL reset_retry: got %0d expected 0", retry_count);
    end
    checks++;
    if (id_value !== 32'd0 || timestamp_value !== 32'd0) begin
      errors++;
      $display("FAIL reset_words: got %0h/%0h expected 0/0", id_value, timestamp_value);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_nominal();
    bad_id_passes = 0;
    do_reset();
    run_check(20, NEVER, 0, -1);
    checks++;
    if (e1_busy !== 1'b1 || e1_read !== 1'b0) begin
      errors++;
      $display("FAIL nom_edge1: got busy=%b read=%b expected busy=1 read=0", e1_busy, e1_read);
    end
    checks++;
    if (done_edge != 7) begin
      errors++;
      $display("FAIL nom_done_edge: got %0d expected 7", done_edge);
    end
    checks++;
    if (pass !== 1'b1 || fail !== 1'b0 || timeout !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL nom_status: got pass=%b fail=%b to=%b busy=%b expected 1 0 0 0",
               pass, fail, timeout, busy);
    end
    checks++;
    if (retry_count !== 4'd0) begin
      errors++;
      $display("FAIL nom_retry: got %0d expected 0", retry_count);
    end
    checks++;
    if (id_pulses != 1 || ts_pulses != 1 || rd_cycles != 2) begin
      errors++;
      $display("FAIL nom_reads: got id=%0d ts=%0d cycles=%0d expected 1 1 2",
               id_pulses, ts_pulses, rd_cycles);
    end
    checks++;
    if (id_value !== EXP_ID || timestamp_value !== EXP_TS) begin
      errors++;
      $display("FAIL nom_words: got %0d/%0d expected %0d/%0d",
               id_value, timestamp_value, EXP_ID, EXP_TS);
    end
  endtask

  task automatic test_stall();
    bad_id_passes = 0;
    do_reset();
    run_check(30, 4, 9, -1);
    checks++;
    if (rd_addr1_cycles != 6) begin
      errors++;
      $display("FAIL stall_read_hold: got %0d expected 6", rd_addr1_cycles);
    end
    checks++;
    if (done_edge != 12) begin
      errors++;
      $display("FAIL stall_done_edge: got %0d expected 12", done_edge);
    end
    checks++;
    if (pass !== 1'b1 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL stall_status: got pass=%b to=%b expected 1 0", pass, timeout);
    end
  endtask

  task automatic test_retry_fail();
    bad_id_passes = 100;
    do_reset();
    run_check(60, NEVER, 0, -1);
    checks++;
    if (done_edge != 22) begin
      errors++;
      $display("FAIL rfail_done_edge: got %0d expected 22", done_edge);
    end
    checks++;
    if (id_pulses != 4) begin
      errors++;
      $display("FAIL rfail_passes: got %0d expected 4", id_pulses);
    end
    checks++;
    if (fail !== 1'b1 || pass !== 1'b0 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL rfail_status: got fail=%b pass=%b to=%b expected 1 0 0",
               fail, pass, timeout);
    end
    checks++;
    if (retry_count !== 4'd3) begin
      errors++;
      $display("FAIL rfail_retry: got %0d expected 3", retry_count);
    end
    checks++;
    if (id_value !== 32'd0) begin
      errors++;
      $display("FAIL rfail_id: got %0h expected 0", id_value);
    end
  endtask

  // Restart from the failed DONE state left by test_retry_fail.
  task automatic test_start_done();
    bad_id_passes = 0;
    run_check(20, NEVER, 0, 0);
    checks++;
    if (e1_done !== 1'b0 || e1_fail !== 1'b0 || e1_pass !== 1'b0 || e1_retry !== 4'd0) begin
      errors++;
      $display("FAIL restart_clear: got done=%b fail=%b pass=%b retry=%0d expected 0 0 0 0",
               e1_done, e1_fail, e1_pass, e1_retry);
    end
    checks++;
    if (e1_read !== 1'b1 || e1_busy !== 1'b1) begin
      errors++;
      $display("FAIL restart_read: got read=%b busy=%b expected 1 1", e1_read, e1_busy);
    end
    checks++;
    if (e1_id !== 32'd0) begin
      errors++;
      $display("FAIL restart_keep_id: got %0h expected 0", e1_id);
    end
    checks++;
    if (done_edge != 6 || pass !== 1'b1) begin
      errors++;
      $display("FAIL restart_pass: got edge=%0d pass=%b expected 6 1", done_edge, pass);
    end
    checks++;
    if (id_value !== EXP_ID) begin
      errors++;
      $display("FAIL restart_id: got %0d expected %0d", id_value, EXP_ID);
    end
  endtask

  task automatic test_retry_once();
    bad_id_passes = 1;
    do_reset();
    run_check(40, NEVER, 0, -1);
    checks++;
    if (done_edge != 12 || pass !== 1'b1 || fail !== 1'b0) begin
      errors++;
      $display("FAIL ronce_status: got edge=%0d pass=%b fail=%b expected 12 1 0",
               done_edge, pass, fail);
    end
    checks++;
    if (retry_count !== 4'd1 || id_pulses != 2) begin
      errors++;
      $display("FAIL ronce_retry: got retry=%0d passes=%0d expected 1 2",
               retry_count, id_pulses);
    end
  endtask

  task automatic test_timeout();
    bad_id_passes = 0;
    do_reset();
    run_check(40, 0, NEVER, -1);
    checks++;
    if (done_edge != 13) begin
      errors++;
      $display("FAIL to_done_edge: got %0d expected 13", done_edge);
    end
    checks++;
    if (rd_cycles != 11 || read !== 1'b0) begin
      errors++;
      $display("FAIL to_read: got cycles=%0d read=%b expected 11 0", rd_cycles, read);
    end
    checks++;
    if (timeout !== 1'b1 || fail !== 1'b1 || pass !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL to_status: got to=%b fail=%b pass=%b busy=%b expected 1 1 0 0",
               timeout, fail, pass, busy);
    end
    checks++;
    if (retry_count !== 4'd0) begin
      errors++;
      $display("FAIL to_retry: got %0d expected 0", retry_count);
    end
  endtask

  task automatic test_reset_mid();
    bad_id_passes = 0;
    do_reset();
    run_check(3, NEVER, 0, -1);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({read, busy, done, pass, fail, timeout} !== 6'b0 || id_value !== 32'd0) begin
      errors++;
      $display("FAIL midrst_async: got flags=%b id=%0h expected 000000 0",
               {read, busy, done, pass, fail, timeout}, id_value);
    end
    @(negedge clk);
    reset = 1'b0;
    run_check(20, NEVER, 0, -1);
    checks++;
    if (done_edge != 7 || pass !== 1'b1 || id_pulses != 1) begin
      errors++;
      $display("FAIL midrst_rerun: got edge=%0d pass=%b passes=%0d expected 7 1 1",
               done_edge, pass, id_pulses);
    end
  endtask

  task automatic test_start_busy();
    int bad;
    bad_id_passes = 0;
    do_reset();
    run_check(20, NEVER, 0, 3);
    checks++;
    if (done_edge != 7 || pass !== 1'b1 || id_pulses != 1) begin
      errors++;
      $display("FAIL sbusy_run: got edge=%0d pass=%b passes=%0d expected 7 1 1",
               done_edge, pass, id_pulses);
    end
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      if (done !== 1'b1 || busy !== 1'b0 || read !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL sbusy_not_queued: got %0d bad cycles expected 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_stall();
    test_retry_fail();
    test_start_done();
    test_retry_once();
    test_timeout();
    test_reset_mid();
    test_start_busy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
